// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller and the CPU PC-mux wiring.
// State encoding and default vector table placement.
package int_ctrl_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } state_e;

  localparam int VEC_BASE_DEF   = 1000;
  localparam int VEC_STRIDE_DEF = 4;

endpackage

// File: rtl/int_ctrl_if.sv
// CPU-side bundle of the interrupt controller.
// master = CPU core, slave = int_ctrl.
interface int_ctrl_if #(
  parameter int NIRQ = 4,
  parameter int PCW  = 10
);
  logic [NIRQ-1:0] irq;
  logic            mask_we;
  logic [NIRQ-1:0] mask_d;
  logic            ie_set;
  logic            ie_clr;
  logic            reti;
  logic [PCW-1:0]  pc_next_seq;
  logic            z_in;

  logic            take_int;
  logic [PCW-1:0]  vector;
  logic            ret_sel;
  logic [PCW-1:0]  ret_pc;
  logic            z_restore;
  logic            z_saved;
  logic            in_service;
  logic [2:0]      active_id;
  logic [NIRQ-1:0] pending;
  logic [NIRQ-1:0] mask;
  logic            ie;

  modport master (
    output irq, mask_we, mask_d, ie_set, ie_clr,
    output reti, pc_next_seq, z_in,
    input  take_int, vector, ret_sel, ret_pc,
    input  z_restore, z_saved, in_service,
    input  active_id, pending, mask, ie
  );

  modport slave (
    input  irq, mask_we, mask_d, ie_set, ie_clr,
    input  reti, pc_next_seq, z_in,
    output take_int, vector, ret_sel, ret_pc,
    output z_restore, z_saved, in_service,
    output active_id, pending, mask, ie
  );
endinterface

// File: rtl/int_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module int_ctrl_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [2:0]   idx,
  output logic [N-1:0] grant
);
  always_comb begin
    valid = |req;
    idx   = '0;
    grant = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx      = 3'(i);
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/int_ctrl.sv
// Single-level interrupt controller: edge capture, mask, priority,
// zero-latency vectoring and one-slot PC/Z context save.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NIRQ       = 4,
  parameter int PCW        = 10,
  parameter int VEC_BASE   = VEC_BASE_DEF,
  parameter int VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic     clk,
  input  logic     reset,
  int_ctrl_if.slave bus
);
  state_e          state_q, state_d;
  logic [NIRQ-1:0] irq_q;
  logic [NIRQ-1:0] pending_q, pending_d;
  logic [NIRQ-1:0] mask_reg_q, mask_reg_d;
  logic            ie_q, ie_d;
  logic [PCW-1:0]  ret_pc_q, ret_pc_d;
  logic            z_saved_q, z_saved_d;
  logic [2:0]      active_id_q, active_id_d;

  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] elig;
  logic            pe_valid;
  logic [2:0]      pe_idx;
  logic [NIRQ-1:0] pe_grant;
  logic            take;
  logic            do_ret;
  logic [PCW-1:0]  vec_calc;

  assign rise = bus.irq & ~irq_q;
  assign elig = pending_q & mask_reg_q;

  int_ctrl_prio_enc #(.N(NIRQ)) u_prio_enc (
    .req   (elig),
    .valid (pe_valid),
    .idx   (pe_idx),
    .grant (pe_grant)
  );

  assign vec_calc = PCW'(VEC_BASE + int'(pe_idx) * VEC_STRIDE);

  assign take   = !reset && state_q == ST_IDLE && ie_q && pe_valid;
  assign do_ret = !reset && state_q == ST_SERVICE && bus.reti;

  always_comb begin
    state_d     = state_q;
    pending_d   = (pending_q & ~(take ? pe_grant : '0)) | rise;
    mask_reg_d  = bus.mask_we ? bus.mask_d : mask_reg_q;
    ie_d        = ie_q;
    ret_pc_d    = ret_pc_q;
    z_saved_d   = z_saved_q;
    active_id_d = active_id_q;
    // clear has priority when EI and DI collide
    if (bus.ie_set) ie_d = 1'b1;
    if (bus.ie_clr) ie_d = 1'b0;
    if (take) begin
      ret_pc_d    = bus.pc_next_seq;
      z_saved_d   = bus.z_in;
      active_id_d = pe_idx;
      state_d     = ST_SERVICE;
    end
    if (do_ret) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      irq_q       <= '0;
      pending_q   <= '0;
      mask_reg_q  <= '0;
      ie_q        <= 1'b0;
      ret_pc_q    <= '0;
      z_saved_q   <= 1'b0;
      active_id_q <= '0;
    end else begin
      state_q     <= state_d;
      irq_q       <= bus.irq;
      pending_q   <= pending_d;
      mask_reg_q  <= mask_reg_d;
      ie_q        <= ie_d;
      ret_pc_q    <= ret_pc_d;
      z_saved_q   <= z_saved_d;
      active_id_q <= active_id_d;
    end
  end

  assign bus.take_int   = take;
  assign bus.vector     = reset ? '0 : vec_calc;
  assign bus.ret_sel    = do_ret;
  assign bus.z_restore  = do_ret;
  assign bus.ret_pc     = ret_pc_q;
  assign bus.z_saved    = z_saved_q;
  assign bus.in_service = state_q == ST_SERVICE;
  assign bus.active_id  = active_id_q;
  assign bus.pending    = pending_q;
  assign bus.mask       = mask_reg_q;
  assign bus.ie         = ie_q;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl with a take/return event scoreboard.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  typedef struct {
    bit         is_ret;
    logic [9:0] addr;
    logic       z;
  } ev_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  ev_t  sb[$];

  int_ctrl_if #(.NIRQ(4), .PCW(10)) bus ();

  int_ctrl #(
    .NIRQ(4), .PCW(10), .VEC_BASE(1000), .VEC_STRIDE(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic exp_take(logic [9:0] v);
    ev_t e;
    e.is_ret = 1'b0;
    e.addr   = v;
    e.z      = 1'b0;
    sb.push_back(e);
  endtask

  task automatic exp_ret(logic [9:0] pc, logic z);
    ev_t e;
    e.is_ret = 1'b1;
    e.addr   = pc;
    e.z      = z;
    sb.push_back(e);
  endtask

  // monitor: every take/return the DUT presents must match the queue head
  always @(negedge clk) begin
    if (bus.take_int && bus.ret_sel) begin
      checks++;
      errors++;
      $display("FAIL excl: take_int=1 ret_sel=1 expected one-hot");
    end else if (bus.take_int || bus.ret_sel) begin
      ev_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got take=%0d ret=%0d expected none",
                 bus.take_int, bus.ret_sel);
      end else begin
        e = sb.pop_front();
        if (!e.is_ret) begin
          chk("sb_kind_take", {31'd0, bus.take_int}, 32'd1);
          chk("sb_vector", {22'd0, bus.vector}, {22'd0, e.addr});
        end else begin
          chk("sb_kind_ret", {31'd0, bus.ret_sel}, 32'd1);
          chk("sb_ret_pc", {22'd0, bus.ret_pc}, {22'd0, e.addr});
          chk("sb_z_restore", {31'd0, bus.z_restore}, 32'd1);
          chk("sb_z_saved", {31'd0, bus.z_saved}, {31'd0, e.z});
        end
      end
    end
  end

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    bus.irq         = '0;
    bus.mask_we     = 1'b0;
    bus.mask_d      = '0;
    bus.ie_set      = 1'b0;
    bus.ie_clr      = 1'b0;
    bus.reti        = 1'b0;
    bus.pc_next_seq = '0;
    bus.z_in        = 1'b0;
    tick();
    tick();
    neg();
    chk("rst_take", {31'd0, bus.take_int}, 32'd0);
    chk("rst_ret", {31'd0, bus.ret_sel}, 32'd0);
    tick();
    reset = 1'b0;
    neg();
    chk("rst_in_service", {31'd0, bus.in_service}, 32'd0);
    chk("rst_pending", {28'd0, bus.pending}, 32'd0);
    chk("rst_mask", {28'd0, bus.mask}, 32'd0);
    chk("rst_ie", {31'd0, bus.ie}, 32'd0);
    chk("rst_ret_pc", {22'd0, bus.ret_pc}, 32'd0);
    tick();

    // basic take
    bus.mask_we = 1'b1;
    bus.mask_d  = 4'b1111;
    bus.ie_set  = 1'b1;
    tick();
    bus.mask_we = 1'b0;
    bus.ie_set  = 1'b0;
    bus.irq     = 4'b0100;
    neg();
    chk("b_no_take_yet", {31'd0, bus.take_int}, 32'd0);
    tick();
    bus.irq         = 4'b0000;
    bus.pc_next_seq = 10'd37;
    bus.z_in        = 1'b1;
    exp_take(10'd1008);
    neg();
    chk("b_take", {31'd0, bus.take_int}, 32'd1);
    chk("b_vector", {22'd0, bus.vector}, 32'd1008);
    tick();
    bus.z_in = 1'b0;
    neg();
    chk("b_in_service", {31'd0, bus.in_service}, 32'd1);
    chk("b_ret_pc", {22'd0, bus.ret_pc}, 32'd37);
    chk("b_z_saved", {31'd0, bus.z_saved}, 32'd1);
    chk("b_pending", {28'd0, bus.pending}, 32'd0);
    chk("b_active_id", {29'd0, bus.active_id}, 32'd2);
    chk("b_take_off", {31'd0, bus.take_int}, 32'd0);

    // return
    tick();
    bus.reti = 1'b1;
    exp_ret(10'd37, 1'b1);
    neg();
    chk("r_ret_sel", {31'd0, bus.ret_sel}, 32'd1);
    chk("r_z_restore", {31'd0, bus.z_restore}, 32'd1);
    tick();
    neg();
    chk("r_idle", {31'd0, bus.in_service}, 32'd0);
    chk("r_idle_ret_sel", {31'd0, bus.ret_sel}, 32'd0);
    chk("r_idle_z_restore", {31'd0, bus.z_restore}, 32'd0);
    tick();
    bus.reti = 1'b0;

    // priority
    bus.irq = 4'b1010;
    tick();
    bus.irq         = 4'b0000;
    bus.pc_next_seq = 10'd100;
    exp_take(10'd1004);
    neg();
    chk("p_take", {31'd0, bus.take_int}, 32'd1);
    chk("p_vector", {22'd0, bus.vector}, 32'd1004);
    tick();
    neg();
    chk("p_active_id", {29'd0, bus.active_id}, 32'd1);
    chk("p_pending", {28'd0, bus.pending}, 32'd8);
    tick();
    bus.reti = 1'b1;
    exp_ret(10'd100, 1'b0);
    tick();
    bus.reti        = 1'b0;
    bus.pc_next_seq = 10'd200;
    bus.z_in        = 1'b1;
    exp_take(10'd1012);
    neg();
    chk("p_b2b_take", {31'd0, bus.take_int}, 32'd1);
    chk("p_b2b_vector", {22'd0, bus.vector}, 32'd1012);
    tick();
    bus.z_in = 1'b0;
    neg();
    chk("p_b2b_id", {29'd0, bus.active_id}, 32'd3);
    bus.reti = 1'b1;
    exp_ret(10'd200, 1'b1);
    tick();
    bus.reti = 1'b0;

    // masking
    bus.mask_we = 1'b1;
    bus.mask_d  = 4'b0001;
    tick();
    bus.mask_we = 1'b0;
    bus.irq     = 4'b0100;
    tick();
    bus.irq = 4'b0000;
    neg();
    chk("m_pending", {28'd0, bus.pending}, 32'd4);
    chk("m_no_take", {31'd0, bus.take_int}, 32'd0);
    tick();
    bus.mask_we = 1'b1;
    bus.mask_d  = 4'b0100;
    neg();
    chk("m_old_mask", {31'd0, bus.take_int}, 32'd0);
    tick();
    bus.mask_we     = 1'b0;
    bus.irq         = 4'b0100;
    bus.pc_next_seq = 10'd300;
    exp_take(10'd1008);
    neg();
    chk("m_take", {31'd0, bus.take_int}, 32'd1);
    tick();
    bus.irq = 4'b0000;
    neg();
    chk("c_set_wins", {28'd0, bus.pending}, 32'd4);
    chk("c_ret_pc", {22'd0, bus.ret_pc}, 32'd300);

    // enable collision
    bus.ie_set = 1'b1;
    bus.ie_clr = 1'b1;
    tick();
    bus.ie_set = 1'b0;
    bus.ie_clr = 1'b0;
    neg();
    chk("e_clr_wins", {31'd0, bus.ie}, 32'd0);
    bus.reti = 1'b1;
    exp_ret(10'd300, 1'b0);
    tick();
    bus.reti = 1'b0;
    neg();
    chk("e_ie_blocks", {31'd0, bus.take_int}, 32'd0);
    bus.ie_set = 1'b1;
    tick();
    bus.ie_set      = 1'b0;
    bus.pc_next_seq = 10'd400;
    exp_take(10'd1008);
    neg();
    chk("e_take", {31'd0, bus.take_int}, 32'd1);
    tick();
    neg();
    chk("e_in_service", {31'd0, bus.in_service}, 32'd1);

    // reset mid-service
    reset    = 1'b1;
    bus.reti = 1'b1;
    neg();
    chk("x_ret_in_rst", {31'd0, bus.ret_sel}, 32'd0);
    tick();
    neg();
    chk("x_in_service", {31'd0, bus.in_service}, 32'd0);
    chk("x_ret_pc", {22'd0, bus.ret_pc}, 32'd0);
    chk("x_pending", {28'd0, bus.pending}, 32'd0);
    chk("x_mask", {28'd0, bus.mask}, 32'd0);
    chk("x_ie", {31'd0, bus.ie}, 32'd0);
    chk("x_take", {31'd0, bus.take_int}, 32'd0);
    tick();
    reset    = 1'b0;
    bus.reti = 1'b0;
    tick();
    tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
